video_timing_gen: RTL and testbench

Parametrised successor to the fixed-mode VGA sync generator in the video controller. It produces HS/VS/BLANK for any mode described by parameters, and advances only on a pixel-enable tick so one clock can serve several pixel rates. It also emits pixel-coordinate requests LAT ticks ahead of the display signals, so a frame-buffer read path with fixed latency lines up exactly with the sync outputs. It sits between the frame-buffer FIFO reader and `video_if`.

---
 rtl/video_timing_pkg.sv | 52 +++++
 rtl/video_delay_line.sv | 43 ++++
 rtl/video_timing_gen.sv | 160 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Video timing package: the display mode description, helpers that derive
// line/frame totals and counter widths from a mode, and the predefined modes.
package video_timing_pkg;

    // One display mode: per-axis active size, front porch, sync width and
    // back porch, plus sync polarity (0 = active-low).
    typedef struct packed {
        int unsigned hdisp;
        int unsigned hfp;
        int unsigned hpulse;
        int unsigned hbp;
        int unsigned vdisp;
        int unsigned vfp;
        int unsigned vpulse;
        int unsigned vbp;
        logic        hs_pol;
        logic        vs_pol;
    } vt_mode_t;

    function automatic int unsigned htotal(vt_mode_t m);
        return m.hdisp + m.hfp + m.hpulse + m.hbp;
    endfunction

    function automatic int unsigned vtotal(vt_mode_t m);
        return m.vdisp + m.vfp + m.vpulse + m.vbp;
    endfunction

    // Bits needed to hold 0..n-1; never less than one bit.
    function automatic int unsigned cnt_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam vt_mode_t MODE_800x480 = '{
        hdisp: 800, hfp: 40, hpulse: 48, hbp: 40,
        vdisp: 480, vfp: 13, vpulse: 3,  vbp: 29,
        hs_pol: 1'b0, vs_pol: 1'b0
    };

    localparam vt_mode_t MODE_640x480 = '{
        hdisp: 640, hfp: 16, hpulse: 96, hbp: 48,
        vdisp: 480, vfp: 10, vpulse: 2,  vbp: 33,
        hs_pol: 1'b0, vs_pol: 1'b0
    };

    // Small mode for simulation: 176 ticks per line, 96 lines per frame.
    localparam vt_mode_t MODE_160x90_SIM = '{
        hdisp: 160, hfp: 4, hpulse: 8, hbp: 4,
        vdisp: 90,  vfp: 2, vpulse: 2, vbp: 2,
        hs_pol: 1'b0, vs_pol: 1'b0
    };

endpackage

// File: rtl/video_delay_line.sv
// ce-gated shift register used to align sync/blank with a fixed-latency
// read path. DEPTH=0 is a pure pass-through with no register.
// Ports:
//   clk_i   clock (rising edge)
//   rst_ni  asynchronous active-low reset, clears every stage to 0
//   ce_i    advance enable; stages hold while low
//   d_i     data in (WIDTH bits)
//   q_o     data out, DEPTH ce-ticks after d_i
module video_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ce_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ok;
        assign unused_ok = ^{clk_i, rst_ni, ce_i};
        assign q_o       = d_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else if (ce_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised video timing generator. Horizontal/vertical counters advance
// on the pixel tick (ce). A registered request stage emits the pixel
// coordinate to fetch; sync and blank follow LAT ticks later so a fixed-
// latency frame-buffer read lines up with the display-aligned outputs.
// Ports:
//   pixel_clk      clock (rising edge)
//   pixel_rst_n    asynchronous active-low reset
//   ce             pixel tick; nothing advances while low
//   req_x, req_y   requested coordinate, 0 outside the active area
//   req_valid      request lies in the active area
//   sof            one-tick pulse on the request for (0,0)
//   video_hs       horizontal sync, display-aligned, polarity HS_POL
//   video_vs       vertical sync, display-aligned, polarity VS_POL
//   video_blank_n  1 = active pixel, display-aligned
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned HDISP  = MODE_800x480.hdisp,
    parameter int unsigned VDISP  = MODE_800x480.vdisp,
    parameter int unsigned HFP    = MODE_800x480.hfp,
    parameter int unsigned HPULSE = MODE_800x480.hpulse,
    parameter int unsigned HBP    = MODE_800x480.hbp,
    parameter int unsigned VFP    = MODE_800x480.vfp,
    parameter int unsigned VPULSE = MODE_800x480.vpulse,
    parameter int unsigned VBP    = MODE_800x480.vbp,
    parameter bit          HS_POL = MODE_800x480.hs_pol,
    parameter bit          VS_POL = MODE_800x480.vs_pol,
    parameter int unsigned LAT    = 2
) (
    input  logic                        pixel_clk,
    input  logic                        pixel_rst_n,
    input  logic                        ce,
    output logic [cnt_width(HDISP)-1:0] req_x,
    output logic [cnt_width(VDISP)-1:0] req_y,
    output logic                        req_valid,
    output logic                        sof,
    output logic                        video_hs,
    output logic                        video_vs,
    output logic                        video_blank_n
);

    localparam vt_mode_t MODE = '{
        hdisp: HDISP, hfp: HFP, hpulse: HPULSE, hbp: HBP,
        vdisp: VDISP, vfp: VFP, vpulse: VPULSE, vbp: VBP,
        hs_pol: HS_POL, vs_pol: VS_POL
    };

    localparam int unsigned HTOTAL = htotal(MODE);
    localparam int unsigned VTOTAL = vtotal(MODE);
    localparam int unsigned HCW    = cnt_width(HTOTAL);
    localparam int unsigned VCW    = cnt_width(VTOTAL);
    localparam int unsigned XW     = cnt_width(HDISP);
    localparam int unsigned YW     = cnt_width(VDISP);

    localparam logic [HCW-1:0] HLast     = HCW'(HTOTAL - 1);
    localparam logic [HCW-1:0] HDispEnd  = HCW'(HDISP);
    localparam logic [HCW-1:0] HSyncBeg  = HCW'(HDISP + HFP);
    localparam logic [HCW-1:0] HSyncEnd  = HCW'(HDISP + HFP + HPULSE);
    localparam logic [VCW-1:0] VLast     = VCW'(VTOTAL - 1);
    localparam logic [VCW-1:0] VDispEnd  = VCW'(VDISP);
    localparam logic [VCW-1:0] VSyncBeg  = VCW'(VDISP + VFP);
    localparam logic [VCW-1:0] VSyncEnd  = VCW'(VDISP + VFP + VPULSE);

    if (HDISP < 1 || VDISP < 1 || HFP < 1 || HPULSE < 1 || HBP < 1 ||
        VFP < 1 || VPULSE < 1 || VBP < 1 || LAT > 15) begin : g_param_check
        $error("video_timing_gen: mode sizes must be >= 1 and LAT <= 15");
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic [VCW-1:0] vcnt_q, vcnt_d;

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (ce) begin
            if (hcnt_q == HLast) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request stage: decode of the pre-increment counter values
    // ------------------------------------------------------------------
    logic          req_valid_q, req_valid_d;
    logic          sof_q, sof_d;
    logic [XW-1:0] req_x_q, req_x_d;
    logic [YW-1:0] req_y_q, req_y_d;
    logic          hs_raw_q, hs_raw_d;
    logic          vs_raw_q, vs_raw_d;

    always_comb begin
        req_valid_d = (hcnt_q < HDispEnd) && (vcnt_q < VDispEnd);
        req_x_d     = '0;
        req_y_d     = '0;
        if (req_valid_d) begin
            req_x_d = hcnt_q[XW-1:0];
            req_y_d = vcnt_q[YW-1:0];
        end
        sof_d    = (hcnt_q == '0) && (vcnt_q == '0);
        // Raw syncs are 1 inside the pulse, independent of polarity.
        hs_raw_d = (hcnt_q >= HSyncBeg) && (hcnt_q < HSyncEnd);
        vs_raw_d = (vcnt_q >= VSyncBeg) && (vcnt_q < VSyncEnd);
    end

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            req_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            req_x_q     <= '0;
            req_y_q     <= '0;
            hs_raw_q    <= 1'b0;
            vs_raw_q    <= 1'b0;
        end else if (ce) begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            req_valid_q <= req_valid_d;
            sof_q       <= sof_d;
            req_x_q     <= req_x_d;
            req_y_q     <= req_y_d;
            hs_raw_q    <= hs_raw_d;
            vs_raw_q    <= vs_raw_d;
        end
    end

    assign req_valid = req_valid_q;
    assign sof       = sof_q;
    assign req_x     = req_x_q;
    assign req_y     = req_y_q;

    // ------------------------------------------------------------------
    // Display stage: LAT-tick delay of {hs_raw, vs_raw, valid}. The all-zero
    // reset encoding is the inactive state for every polarity.
    // ------------------------------------------------------------------
    logic [2:0] disp;

    video_delay_line #(
        .WIDTH(3),
        .DEPTH(LAT)
    ) u_delay (
        .clk_i (pixel_clk),
        .rst_ni(pixel_rst_n),
        .ce_i  (ce),
        .d_i   ({hs_raw_q, vs_raw_q, req_valid_q}),
        .q_o   (disp)
    );

    assign video_hs      = disp[2] ^ ~HS_POL;
    assign video_vs      = disp[1] ^ ~VS_POL;
    assign video_blank_n = disp[0];

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

    localparam int HD = 160, VD = 90;
    localparam int HFP = 4, HPW = 8, HBP = 4;
    localparam int VFP = 2, VPW = 2, VBP = 2;
    localparam int HT = HD + HFP + HPW + HBP;   // 176
    localparam int VT = VD + VFP + VPW + VBP;   // 96
    localparam int FRAME = HT * VT;             // 16896

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;

    logic [7:0] a_x, b_x;
    logic [6:0] a_y, b_y;
    logic a_v, a_sof, a_hs, a_vs, a_bn;
    logic b_v, b_sof, b_hs, b_vs, b_bn;

    always #5 clk = ~clk;

    // Default polarity, LAT=2
    video_timing_gen #(
        .HDISP(HD), .VDISP(VD), .HFP(HFP), .HPULSE(HPW), .HBP(HBP),
        .VFP(VFP), .VPULSE(VPW), .VBP(VBP), .HS_POL(1'b0), .VS_POL(1'b0), .LAT(2)
    ) dut_a (
        .pixel_clk(clk), .pixel_rst_n(rst_n), .ce(ce),
        .req_x(a_x), .req_y(a_y), .req_valid(a_v), .sof(a_sof),
        .video_hs(a_hs), .video_vs(a_vs), .video_blank_n(a_bn)
    );

    // Active-high syncs, LAT=0
    video_timing_gen #(
        .HDISP(HD), .VDISP(VD), .HFP(HFP), .HPULSE(HPW), .HBP(HBP),
        .VFP(VFP), .VPULSE(VPW), .VBP(VBP), .HS_POL(1'b1), .VS_POL(1'b1), .LAT(0)
    ) dut_b (
        .pixel_clk(clk), .pixel_rst_n(rst_n), .ce(ce),
        .req_x(b_x), .req_y(b_y), .req_valid(b_v), .sof(b_sof),
        .video_hs(b_hs), .video_vs(b_vs), .video_blank_n(b_bn)
    );

    int checks = 0;
    int failures = 0;
    int ticks = 0;       // ce ticks since last reset release
    int cyc = 0;
    int phase = 0;

    // Packed layout: {valid, sof, x[7:0], y[6:0], hs, vs, blank_n}
    function automatic logic [19:0] pack_a();
        return {a_v, a_sof, a_x, a_y, a_hs, a_vs, a_bn};
    endfunction

    function automatic logic [19:0] pack_b();
        return {b_v, b_sof, b_x, b_y, b_hs, b_vs, b_bn};
    endfunction

    // Expected outputs after n ticks: the n-th request covers raster position
    // n-1 of the frame; the display outputs show the request of tick n-lat.
    function automatic logic [19:0] exp_vec(int n, int lat, bit pol_h, bit pol_v);
        int p, x, y, m;
        logic v, s, hr, vr, bv;
        logic [7:0] ex;
        logic [6:0] ey;
        v = 0; s = 0; hr = 0; vr = 0; bv = 0; ex = '0; ey = '0;
        if (n > 0) begin
            p = (n - 1) % FRAME;
            x = p % HT;
            y = p / HT;
            v = (x < HD) && (y < VD);
            s = (p == 0);
            if (v) begin
                ex = 8'(x);
                ey = 7'(y);
            end
        end
        m = n - lat;
        if (m > 0) begin
            p = (m - 1) % FRAME;
            x = p % HT;
            y = p / HT;
            hr = (x >= HD + HFP) && (x < HD + HFP + HPW);
            vr = (y >= VD + VFP) && (y < VD + VFP + VPW);
            bv = (x < HD) && (y < VD);
        end
        return {v, s, ex, ey, hr ^ ~pol_h, vr ^ ~pol_v, bv};
    endfunction

    task automatic check_lit(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, expv, expv);
        end
    endtask

    // Phase-1 statistics
    int sof_ticks[$];
    int hs_fall = -1, hs_rise = -1, hs_low_line = 0, blank_cnt = 0, first_bn = -1;
    int seen[VD][HD];
    int out_of_range = 0;
    // Phase-2 statistics (clock-cycle stamps)
    int c_fall1 = -1, c_fall2 = -1, c_rise1 = -1, c_bn_rise = -1, c_bn_fall = -1;
    logic prev_a_hs = 1'b1, prev_a_bn = 1'b0;
    logic [19:0] prev_aa = '0;

    // One clock: drive ce, advance the model on the edge, compare at negedge.
    task automatic step(input bit c);
        logic [19:0] aa, ab, ea, eb;
        ce = c;
        @(posedge clk);
        cyc++;
        if (rst_n && ce) ticks++;
        @(negedge clk);
        aa = pack_a();
        ab = pack_b();
        ea = exp_vec(ticks, 2, 1'b0, 1'b0);
        eb = exp_vec(ticks, 0, 1'b1, 1'b1);
        checks++;
        if (aa !== ea) begin
            failures++;
            $display("FAIL model_a tick=%0d: got %05h, expected %05h", ticks, aa, ea);
        end
        checks++;
        if (ab !== eb) begin
            failures++;
            $display("FAIL model_b tick=%0d: got %05h, expected %05h", ticks, ab, eb);
        end
        if (phase == 1) begin
            if (a_sof) sof_ticks.push_back(ticks);
            if (prev_a_hs && !a_hs && hs_fall < 0) hs_fall = ticks;
            if (!prev_a_hs && a_hs && hs_fall >= 0 && hs_rise < 0) hs_rise = ticks;
            if (!a_hs && ticks >= 3 && ticks < 3 + HT) hs_low_line++;
            if (a_bn && ticks <= FRAME + 2) blank_cnt++;
            if (a_bn && first_bn < 0) first_bn = ticks;
            if (a_v) begin
                if (a_x < HD && a_y < VD) seen[a_y][a_x]++;
                else out_of_range++;
            end
        end
        if (phase == 2) begin
            if (!c) begin
                checks++;
                if (aa !== prev_aa) begin
                    failures++;
                    $display("FAIL hold_ce0 cyc=%0d: got %05h, expected %05h", cyc, aa, prev_aa);
                end
            end
            if (prev_a_hs && !a_hs) begin
                if (c_fall1 < 0) c_fall1 = cyc;
                else if (c_fall2 < 0) c_fall2 = cyc;
            end
            if (!prev_a_hs && a_hs && c_fall1 >= 0 && c_rise1 < 0) c_rise1 = cyc;
            if (!prev_a_bn && a_bn && c_bn_rise < 0) c_bn_rise = cyc;
            if (prev_a_bn && !a_bn && c_bn_rise >= 0 && c_bn_fall < 0) c_bn_fall = cyc;
        end
        prev_a_hs = a_hs;
        prev_a_bn = a_bn;
        prev_aa   = aa;
    endtask

    initial begin
        int bad;
        // ---------------- reset state ----------------
        #2;
        check_lit("reset_a", int'(pack_a()), 32'h00006);
        check_lit("reset_b", int'(pack_b()), 32'h00000);
        step(1'b0);
        step(1'b1);              // ce during reset must not advance anything
        rst_n = 1'b1;

        // ---------------- phase 1: three frames, continuous ce ----------------
        phase = 1;
        step(1'b1);
        check_lit("first_tick_b", int'(pack_b()), 32'hC0001);
        for (int i = 1; i < 3 * FRAME; i++) step(1'b1);
        phase = 0;

        check_lit("sof_count", sof_ticks.size(), 3);
        if (sof_ticks.size() == 3) begin
            check_lit("sof_tick0", sof_ticks[0], 1);
            check_lit("sof_tick1", sof_ticks[1], 16897);
            check_lit("sof_tick2", sof_ticks[2], 33793);
        end
        check_lit("hs_first_fall", hs_fall, 167);
        check_lit("hs_first_rise", hs_rise, 175);
        check_lit("hs_low_per_line", hs_low_line, 8);
        check_lit("first_blank_tick", first_bn, 3);
        check_lit("blank_per_frame", blank_cnt, 14400);
        bad = 0;
        for (int y = 0; y < VD; y++)
            for (int x = 0; x < HD; x++)
                if (seen[y][x] != 3) bad++;
        check_lit("coord_not_seen_3x", bad, 0);
        check_lit("coord_out_of_range", out_of_range, 0);

        // ---------------- phase 2: ce every 4th clock ----------------
        rst_n = 1'b0;
        ticks = 0;
        step(1'b0);
        step(1'b0);
        rst_n = 1'b1;
        phase = 2;
        for (int i = 0; i < 2000; i++) step(i % 4 == 0);
        phase = 0;
        check_lit("ce4_hs_width", c_rise1 - c_fall1, 32);
        check_lit("ce4_hs_period", c_fall2 - c_fall1, 704);
        check_lit("ce4_blank_width", c_bn_fall - c_bn_rise, 640);

        // ---------------- phase 3: asynchronous reset mid-frame ----------------
        rst_n = 1'b0;
        ticks = 0;
        step(1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 30 * HT + 50; i++) step(1'b1);
        // Counters now sit at hcnt=50, vcnt=30; reset between clock edges.
        #2;
        rst_n = 1'b0;
        ticks = 0;
        #1;
        check_lit("async_reset_a", int'(pack_a()), 32'h00006);
        check_lit("async_reset_b", int'(pack_b()), 32'h00000);
        step(1'b1);
        step(1'b0);
        rst_n = 1'b1;
        step(1'b1);
        check_lit("post_reset_first_a", int'(pack_a()), 32'hC0006);
        check_lit("post_reset_first_b", int'(pack_b()), 32'hC0001);
        for (int i = 0; i < 8; i++) step(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
